risk_order_gate: RTL and testbench
==================================

# risk_order_gate

Order-path enforcement block sitting downstream of the risk engine: it consumes the risk verdict stream (allow_trade / kill_switch) and applies it to the outgoing order stream. Orders pass through a one-entry registered stage only while the latest verdict allows trading. Once a kill verdict arrives, the block latches it, flushes and drops all orders, and counts them until software clears the kill.

## Interface
- DROP_CNT_W, 16, width of the saturating dropped-order counter
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- risk_valid  in  1  verdict valid
- risk_ready  out  1  verdict ready; constant 1 outside reset
- risk_allow  in  1  allow_trade from the risk engine
- risk_kill  in  1  kill_switch from the risk engine
- ord_in_valid  in  1  order valid
- ord_in_ready  out  1  order accepted when valid && ready
- ord_in_qty  in  32  signed Q16.16 order quantity
- ord_in_side  in  1  0 = buy, 1 = sell
- ord_out_valid  out  1  gated order valid
- ord_out_ready  in  1  downstream ready
- ord_out_qty  out  32  registered copy of ord_in_qty, bit-exact
- ord_out_side  out  1  registered copy of ord_in_side
- kill_clear  in  1  single-cycle pulse; releases the kill latch
- kill_latched  out  1  high while the state is KILLED
- gate_state  out  2  00 WAIT, 01 ARMED, 10 HOLD, 11 KILLED
- drop_count  out  DROP_CNT_W  orders dropped since reset; saturates at all-ones

## Operation
- States:
  - WAIT: reset state, also entered after a kill is cleared; no verdict held yet.
  - ARMED: orders flow.
  - HOLD: orders stall (not dropped).
  - KILLED: orders are dropped.
- Verdict decode, applied on any risk_valid cycle:
  - risk_kill=1 → KILLED. Kill has priority over allow.
  - Else risk_allow=1 → ARMED.
  - Else → HOLD.
- In KILLED, further verdicts are ignored. Only kill_clear (with risk_kill not asserted by a valid verdict that cycle) moves KILLED → WAIT.
- kill_clear is ignored in every state other than KILLED. If kill_clear and a valid kill verdict occur in the same cycle, the block stays in KILLED.
- ord_in_ready by state:
  - ARMED: `!ord_out_valid || ord_out_ready`.
  - WAIT, HOLD: 0.
  - KILLED: 1. Accepted orders are discarded and drop_count increments by 1.
- Output register:
  - Loads on an accepted order in ARMED; ord_out_valid=1 next cycle.
  - Clears ord_out_valid on a consume with no new load.
  - Holds qty/side stable while valid && !ready.
- Entering HOLD: an order already in the output register remains valid and may still be consumed. Only new acceptance stops.
- Entering KILLED with ord_out_valid=1 and not consumed that cycle: the entry is flushed (ord_out_valid=0 next cycle) and counted as one drop. A flush and an input drop in the same cycle add 2.
- drop_count saturates at 2^DROP_CNT_W−1. It is not cleared by kill_clear, only by rst.
- No arithmetic is performed on qty. Q16.16 passes through unchanged.

## Timing
- Reset values: risk_ready=0 during rst (1 from the first cycle after release), ord_in_ready=0, ord_out_valid=0, ord_out_qty=0, ord_out_side=0, kill_latched=0, gate_state=WAIT, drop_count=0.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously). Any order held in the output register is lost and is not counted.
- Verdict at edge t updates the state at t+1. Order acceptance in cycle t uses the state before the edge, so a simultaneous order and verdict is judged by the old state.
- Order latency: 1 cycle from accept to ord_out_valid in ARMED. Full throughput of 1 order/cycle when ord_out_ready=1.
- A kill verdict sampled at edge t gives ord_out_valid=0 and kill_latched=1 from t+1, unless the output entry was consumed at edge t.
- A kill_clear sampled at edge t gives gate_state=WAIT at t+1. Orders remain blocked until the next allow verdict.

## Test plan
- Reset, then an order with no verdict → ord_in_ready=0 and gate_state=00. Send verdict allow=1, kill=0, then order qty=0x0001_8000 side=0 → ord_out_valid one cycle later with qty 0x0001_8000; drop_count=0.
- ARMED streaming of 8 orders with ord_out_ready=1 → 8 outputs on consecutive cycles, in order, bit-exact. With ord_out_ready=0 → exactly one order accepted and held stable.
- Output entry pending with ord_out_ready=0, then verdict kill=1 → next cycle ord_out_valid=0, kill_latched=1, drop_count=1. Then 3 orders → all accepted, drop_count=4, ord_out_valid stays 0.
- In KILLED, verdict allow=1 → stays KILLED. kill_clear together with a valid kill verdict → stays KILLED. kill_clear alone → gate_state=WAIT, drop_count unchanged at 4.
- Verdict allow=0, kill=0 with an order pending → pending order still delivered, no new acceptance, drop_count unchanged. Verdict allow=1, kill=1 → KILLED.
- DROP_CNT_W=4 with 20 orders dropped → drop_count=15 (saturated). Assert rst mid-stream → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/risk_order_gate.sv
// Order-path kill gate: applies the latest risk verdict to a one-entry registered order stage.
// Orders flow in ARMED, stall in WAIT/HOLD, and are dropped and counted in KILLED until kill_clear.
module risk_order_gate #(
   parameter int DROP_CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         risk_valid,
   output logic                         risk_ready,
   input  logic                         risk_allow,
   input  logic                         risk_kill,
   input  logic                         ord_in_valid,
   output logic                         ord_in_ready,
   input  logic signed [31:0]           ord_in_qty,
   input  logic                         ord_in_side,
   output logic                         ord_out_valid,
   input  logic                         ord_out_ready,
   output logic signed [31:0]           ord_out_qty,
   output logic                         ord_out_side,
   input  logic                         kill_clear,
   output logic                         kill_latched,
   output logic [1:0]                   gate_state,
   output logic [DROP_CNT_W-1:0]        drop_count
);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'b00,
      ST_ARMED  = 2'b01,
      ST_HOLD   = 2'b10,
      ST_KILLED = 2'b11
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_risk_ready;
   logic                    r_out_vld;
   logic signed [31:0]      r_out_qty;
   logic                    r_out_side;
   logic [DROP_CNT_W-1:0]   r_drop_cnt;

   logic                    w_in_ready;
   logic                    w_accept;
   logic                    w_load;
   logic                    w_in_drop;
   logic                    w_consume;
   logic                    w_kill_entry;
   logic                    w_flush;
   logic                    w_load_drop;
   logic [1:0]              w_drop_inc;

   function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                     input logic [1:0] inc);
      logic [DROP_CNT_W:0] s;
      s = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, inc};
      if (s[DROP_CNT_W]) sat_add = '1;
      else               sat_add = s[DROP_CNT_W-1:0];
   endfunction

   // Verdict decode; kill wins over allow, and a latched kill only yields to a clean kill_clear
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_KILLED: begin
            if (kill_clear && !(risk_valid && risk_kill)) w_state_nxt = ST_WAIT;
         end
         default: begin
            if (risk_valid) begin
               if (risk_kill)       w_state_nxt = ST_KILLED;
               else if (risk_allow) w_state_nxt = ST_ARMED;
               else                 w_state_nxt = ST_HOLD;
            end
         end
      endcase
   end

   always_comb begin
      w_in_ready = 1'b0;
      case (r_state)
         ST_ARMED:  w_in_ready = !r_out_vld || ord_out_ready;
         ST_KILLED: w_in_ready = 1'b1;
         default:   w_in_ready = 1'b0;
      endcase
   end

   assign w_accept     = ord_in_valid && w_in_ready;
   assign w_load       = w_accept && (r_state == ST_ARMED);
   assign w_in_drop    = w_accept && (r_state == ST_KILLED);
   assign w_consume    = r_out_vld && ord_out_ready;
   assign w_kill_entry = (r_state != ST_KILLED) && (w_state_nxt == ST_KILLED);
   // An order accepted on the kill edge never leaves the block, so it is counted too
   assign w_flush      = w_kill_entry && r_out_vld && !ord_out_ready;
   assign w_load_drop  = w_kill_entry && w_load;
   assign w_drop_inc   = {1'b0, w_flush} + {1'b0, (w_in_drop || w_load_drop)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_WAIT;
         r_risk_ready <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_risk_ready <= 1'b1;
         r_drop_cnt   <= sat_add(r_drop_cnt, w_drop_inc);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_vld  <= 1'b0;
         r_out_qty  <= '0;
         r_out_side <= 1'b0;
      end else begin
         if (w_kill_entry)   r_out_vld <= 1'b0;
         else if (w_load)    r_out_vld <= 1'b1;
         else if (w_consume) r_out_vld <= 1'b0;
         if (w_load && !w_kill_entry) begin
            r_out_qty  <= ord_in_qty;
            r_out_side <= ord_in_side;
         end
      end
   end

   assign risk_ready    = r_risk_ready;
   assign ord_in_ready  = w_in_ready;
   assign ord_out_valid = r_out_vld;
   assign ord_out_qty   = r_out_qty;
   assign ord_out_side  = r_out_side;
   assign kill_latched  = (r_state == ST_KILLED);
   assign gate_state    = r_state;
   assign drop_count    = r_drop_cnt;

endmodule

// File: tb/tb_risk_order_gate.sv
// Bench for risk_order_gate: scenario tasks with inline checks plus an output scoreboard.
module tb_risk_order_gate;

   localparam int DW = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 risk_valid = 1'b0;
   logic                 risk_ready;
   logic                 risk_allow = 1'b0;
   logic                 risk_kill = 1'b0;
   logic                 ord_in_valid = 1'b0;
   logic                 ord_in_ready;
   logic signed [31:0]   ord_in_qty = '0;
   logic                 ord_in_side = 1'b0;
   logic                 ord_out_valid;
   logic                 ord_out_ready = 1'b0;
   logic signed [31:0]   ord_out_qty;
   logic                 ord_out_side;
   logic                 kill_clear = 1'b0;
   logic                 kill_latched;
   logic [1:0]           gate_state;
   logic [DW-1:0]        drop_count;

   int checks = 0;
   int failures = 0;
   int n_out = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   risk_order_gate #(.DROP_CNT_W(DW)) dut (
      .clk(clk), .rst(rst),
      .risk_valid(risk_valid), .risk_ready(risk_ready),
      .risk_allow(risk_allow), .risk_kill(risk_kill),
      .ord_in_valid(ord_in_valid), .ord_in_ready(ord_in_ready),
      .ord_in_qty(ord_in_qty), .ord_in_side(ord_in_side),
      .ord_out_valid(ord_out_valid), .ord_out_ready(ord_out_ready),
      .ord_out_qty(ord_out_qty), .ord_out_side(ord_out_side),
      .kill_clear(kill_clear), .kill_latched(kill_latched),
      .gate_state(gate_state), .drop_count(drop_count)
   );

   // Scoreboard: every consumed output must match the oldest expected order
   always @(negedge clk) begin
      if (!rst && ord_out_valid && ord_out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected got side=%0d qty=%h, none expected", ord_out_side, ord_out_qty);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({ord_out_side, ord_out_qty} !== e) begin
               failures++;
               $display("FAIL out_data got %h, expected %h", {ord_out_side, ord_out_qty}, e);
            end
            n_out++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic send_verdict(input logic allow, input logic kill);
      risk_valid = 1'b1; risk_allow = allow; risk_kill = kill;
      cyc();
      risk_valid = 1'b0; risk_allow = 1'b0; risk_kill = 1'b0;
      #2;
   endtask

   task automatic test_reset();
      ord_in_valid = 1'b1;
      #3;
      checks++;
      if ({risk_ready, ord_in_ready, ord_out_valid, ord_out_qty, ord_out_side, kill_latched, gate_state, drop_count} !== '0) begin
         failures++;
         $display("FAIL reset_vals rr=%b ir=%b ov=%b q=%h s=%b k=%b g=%b d=%0d, all zero required",
                  risk_ready, ord_in_ready, ord_out_valid, ord_out_qty, ord_out_side, kill_latched, gate_state, drop_count);
      end
      @(posedge clk); #1 rst = 1'b0;
      cyc(); #2;
      checks++;
      if (risk_ready !== 1'b1) begin failures++; $display("FAIL risk_ready_after got %b want 1", risk_ready); end
      checks++;
      if (ord_in_ready !== 1'b0 || gate_state !== 2'b00) begin
         failures++; $display("FAIL wait_blocks ir=%b g=%b want 0/00", ord_in_ready, gate_state);
      end
      cyc();
      ord_in_valid = 1'b0;
   endtask

   task automatic test_allow_first();
      send_verdict(1'b1, 1'b0);
      checks++;
      if (gate_state !== 2'b01) begin failures++; $display("FAIL armed_state got %b want 01", gate_state); end
      ord_out_ready = 1'b1;
      ord_in_valid = 1'b1; ord_in_qty = 32'h0001_8000; ord_in_side = 1'b0;
      exp_q.push_back({1'b0, 32'h0001_8000});
      cyc();
      ord_in_valid = 1'b0;
      #2;
      checks++;
      if (ord_out_valid !== 1'b1 || ord_out_qty !== 32'h0001_8000 || drop_count !== 0) begin
         failures++; $display("FAIL first_order ov=%b q=%h d=%0d want 1/00018000/0", ord_out_valid, ord_out_qty, drop_count);
      end
      cyc(); #2;
      checks++;
      if (ord_out_valid !== 1'b0 || exp_q.size() != 0) begin
         failures++; $display("FAIL first_drain ov=%b q_left=%0d want 0/0", ord_out_valid, exp_q.size());
      end
   endtask

   task automatic test_stream();
      int base;
      base = n_out;
      ord_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ord_in_valid = 1'b1; ord_in_qty = $urandom; ord_in_side = i[0];
         exp_q.push_back({ord_in_side, ord_in_qty});
         cyc(); #2;
         checks++;
         if (ord_out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid beat %0d got %b want 1", i, ord_out_valid); end
      end
      ord_in_valid = 1'b0;
      cyc(); cyc(); #2;
      checks++;
      if (n_out - base != 8 || exp_q.size() != 0) begin
         failures++; $display("FAIL stream_count got %0d left %0d want 8/0", n_out - base, exp_q.size());
      end
      // stall: one accepted, held stable
      ord_out_ready = 1'b0;
      ord_in_valid = 1'b1; ord_in_qty = 32'hA5A5_0001; ord_in_side = 1'b1;
      exp_q.push_back({1'b1, 32'hA5A5_0001});
      cyc();
      ord_in_qty = 32'h5A5A_0002; ord_in_side = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #2;
         checks++;
         if (ord_in_ready !== 1'b0 || ord_out_valid !== 1'b1 || ord_out_qty !== 32'hA5A5_0001 || ord_out_side !== 1'b1) begin
            failures++; $display("FAIL stall_hold ir=%b ov=%b q=%h s=%b want 0/1/a5a50001/1", ord_in_ready, ord_out_valid, ord_out_qty, ord_out_side);
         end
         cyc();
      end
      ord_in_valid = 1'b0;
   endtask

   task automatic test_kill_flush();
      send_verdict(1'b0, 1'b1);
      void'(exp_q.pop_back());
      checks++;
      if (ord_out_valid !== 1'b0 || kill_latched !== 1'b1 || drop_count !== 1) begin
         failures++; $display("FAIL kill_flush ov=%b k=%b d=%0d want 0/1/1", ord_out_valid, kill_latched, drop_count);
      end
      ord_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ord_in_valid = 1'b1; ord_in_qty = 32'h0000_1000 + i;
         #1;
         checks++;
         if (ord_in_ready !== 1'b1) begin failures++; $display("FAIL killed_ready got %b want 1", ord_in_ready); end
         cyc();
      end
      ord_in_valid = 1'b0;
      #2;
      checks++;
      if (drop_count !== 4 || ord_out_valid !== 1'b0) begin
         failures++; $display("FAIL killed_drops d=%0d ov=%b want 4/0", drop_count, ord_out_valid);
      end
   endtask

   task automatic test_killed_ignore();
      send_verdict(1'b1, 1'b0);
      checks++;
      if (gate_state !== 2'b11) begin failures++; $display("FAIL killed_ignores_allow got %b want 11", gate_state); end
      kill_clear = 1'b1;
      send_verdict(1'b0, 1'b1);
      kill_clear = 1'b0;
      checks++;
      if (gate_state !== 2'b11) begin failures++; $display("FAIL clear_vs_kill got %b want 11", gate_state); end
      kill_clear = 1'b1;
      cyc();
      kill_clear = 1'b0;
      #2;
      checks++;
      if (gate_state !== 2'b00 || kill_latched !== 1'b0 || drop_count !== 4 || ord_in_ready !== 1'b0) begin
         failures++; $display("FAIL kill_clear g=%b k=%b d=%0d ir=%b want 00/0/4/0", gate_state, kill_latched, drop_count, ord_in_ready);
      end
   endtask

   task automatic test_hold();
      send_verdict(1'b1, 1'b0);
      ord_out_ready = 1'b0;
      ord_in_valid = 1'b1; ord_in_qty = 32'hFFFF_8000; ord_in_side = 1'b1;
      exp_q.push_back({1'b1, 32'hFFFF_8000});
      cyc();
      ord_in_valid = 1'b0;
      send_verdict(1'b0, 1'b0);
      checks++;
      if (gate_state !== 2'b10 || ord_out_valid !== 1'b1) begin
         failures++; $display("FAIL hold_entry g=%b ov=%b want 10/1", gate_state, ord_out_valid);
      end
      ord_in_valid = 1'b1; ord_in_qty = 32'h1234_5678; ord_in_side = 1'b0;
      ord_out_ready = 1'b1;
      #1;
      checks++;
      if (ord_in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got %b want 0", ord_in_ready); end
      cyc(); #2;
      checks++;
      if (ord_out_valid !== 1'b0 || exp_q.size() != 0 || drop_count !== 4) begin
         failures++; $display("FAIL hold_drain ov=%b left=%0d d=%0d want 0/0/4", ord_out_valid, exp_q.size(), drop_count);
      end
      ord_in_valid = 1'b0;
      send_verdict(1'b1, 1'b1);
      checks++;
      if (gate_state !== 2'b11 || drop_count !== 4) begin
         failures++; $display("FAIL kill_priority g=%b d=%0d want 11/4", gate_state, drop_count);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 20; i++) begin
         ord_in_valid = 1'b1; ord_in_qty = i;
         cyc();
         if (i == 10) begin
            #2;
            checks++;
            if (drop_count !== 4'hF) begin failures++; $display("FAIL sat_reach got %0d want 15", drop_count); end
         end
      end
      ord_in_valid = 1'b0;
      #2;
      checks++;
      if (drop_count !== 4'hF) begin failures++; $display("FAIL sat_hold got %0d want 15", drop_count); end
   endtask

   task automatic test_reset_mid();
      kill_clear = 1'b1; cyc(); kill_clear = 1'b0;
      send_verdict(1'b1, 1'b0);
      ord_out_ready = 1'b0;
      ord_in_valid = 1'b1; ord_in_qty = 32'h7777_0001; ord_in_side = 1'b1;
      cyc(); #2;
      checks++;
      if (ord_out_valid !== 1'b1) begin failures++; $display("FAIL mid_pending got %b want 1", ord_out_valid); end
      rst = 1'b1;
      #1;
      checks++;
      if ({risk_ready, ord_in_ready, ord_out_valid, ord_out_qty, ord_out_side, kill_latched, gate_state, drop_count} !== '0) begin
         failures++;
         $display("FAIL mid_reset rr=%b ir=%b ov=%b q=%h s=%b k=%b g=%b d=%0d, all zero required",
                  risk_ready, ord_in_ready, ord_out_valid, ord_out_qty, ord_out_side, kill_latched, gate_state, drop_count);
      end
      ord_in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      cyc(); #2;
      checks++;
      if (risk_ready !== 1'b1 || gate_state !== 2'b00 || drop_count !== 0 || ord_out_valid !== 1'b0) begin
         failures++; $display("FAIL post_reset rr=%b g=%b d=%0d ov=%b want 1/00/0/0", risk_ready, gate_state, drop_count, ord_out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_allow_first();
      test_stream();
      test_kill_flush();
      test_killed_ignore();
      test_hold();
      test_saturate();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
